// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged reset generator on the PLL output clock.
// Brings up the SDRAM controller first and then the CPU/system. Before
// releasing anything it waits for a stable PLL lock and the SDRAM power-up
// delay, then waits for the SDRAM controller to report that init is done.
// Any loss of lock restarts the whole sequence from the beginning.
module pll_reset_sequencer #(
  parameter int LOCK_SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES       = 1024,
  parameter int POWERUP_CYCLES      = 13200,
  parameter int INIT_TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       sdram_init_done,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABILIZE,
    POWERUP,
    SDRAM_INIT,
    RUN
  } state_t;

  // Terminal value of the shared counter in each timed state.
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] POWERUP_LAST = CNT_WIDTH'(POWERUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] INIT_LAST    = CNT_WIDTH'(INIT_TIMEOUT_CYCLES - 1);

  // Parameter sanity: every cycle count must fit in the shared counter.
  localparam longint CNT_CAP   = longint'(1) << CNT_WIDTH;
  localparam bit     PARAMS_OK = (LOCK_SYNC_STAGES >= 2) && (STABLE_CYCLES >= 1) &&
                                 (POWERUP_CYCLES >= 1) && (INIT_TIMEOUT_CYCLES >= 1);
  localparam bit     CNT_FITS  = (longint'(STABLE_CYCLES) < CNT_CAP) &&
                                 (longint'(POWERUP_CYCLES) < CNT_CAP) &&
                                 (longint'(INIT_TIMEOUT_CYCLES) < CNT_CAP);

  state_t                      state;
  logic [LOCK_SYNC_STAGES-1:0] lock_sync;
  logic                        lock_s;
  logic [CNT_WIDTH-1:0]        cnt;

  // Flags illegal parameter sets in simulation.
  assert property (@(posedge clk) PARAMS_OK && CNT_FITS)
    else $error("pll_reset_sequencer: illegal parameters or CNT_WIDTH too small");

  // Lock synchronizer: the only path from the asynchronous pll_lock into logic.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) lock_sync <= '0;
    else     lock_sync <= {lock_sync[LOCK_SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = lock_sync[LOCK_SYNC_STAGES-1];

  // Moves to a state and loads the registered outputs for it on the same edge.
  task automatic enter(input state_t s);
    state     <= s;
    sdram_rst <= (s != SDRAM_INIT) && (s != RUN);
    sys_rst   <= (s != RUN);
    ready     <= (s == RUN);
  endtask

  // Sequencer FSM, shared counter, lock-loss counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      sdram_rst       <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      timeout_err     <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if ((state != WAIT_LOCK) && !lock_s) begin
        // Lock loss outranks every other exit, including the timeout.
        enter(WAIT_LOCK);
        cnt <= '0;
        if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
      end else begin
        unique case (state)
          WAIT_LOCK: begin
            cnt <= '0;
            if (lock_s) enter(STABILIZE);
          end
          STABILIZE: begin
            if (cnt == STABLE_LAST) begin
              enter(POWERUP);
              cnt <= '0;
            end
          end
          POWERUP: begin
            if (cnt == POWERUP_LAST) begin
              enter(SDRAM_INIT);
              cnt <= '0;
            end
          end
          SDRAM_INIT: begin
            if (sdram_init_done) begin
              enter(RUN);
              cnt <= '0;
            end else if (cnt == INIT_LAST) begin
              timeout_err <= 1'b1;
              enter(WAIT_LOCK);
              cnt <= '0;
            end
          end
          RUN: begin
            // Counter parked at zero so it never wraps while running.
            cnt <= '0;
          end
          default: begin
            enter(WAIT_LOCK);
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. Expected output snapshots are queued
// with the clock edge they belong to and compared when that edge's outputs
// are visible. Edge numbering: cyc counts rising edges; inputs are driven
// shortly after a falling edge, so an input driven at cyc=D is first
// sampled by edge D+1.
module tb_pll_reset_sequencer;

  localparam int STAGES  = 2;
  localparam int STABLE  = 4;
  localparam int POWERUP = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       sdram_init_done;
  logic       sdram_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic       timeout_err;

  pll_reset_sequencer #(
    .LOCK_SYNC_STAGES   (STAGES),
    .STABLE_CYCLES      (STABLE),
    .POWERUP_CYCLES     (POWERUP),
    .INIT_TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH          (17)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock       (pll_lock),
    .sdram_init_done(sdram_init_done),
    .sdram_rst      (sdram_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected snapshot packing: {sdram_rst, sys_rst, ready, timeout_err, lock_loss_count}
  typedef struct {
    string       tag;
    int          at;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int at, input logic sr, input logic sy,
                           input logic rd, input logic te, input logic [7:0] llc);
    exp_t e;
    e.tag = $sformatf("%s@%0d", tag, at);
    e.at  = at;
    e.val = {sr, sy, rd, te, llc};
    sb.push_back(e);
  endtask

  // Compare every queued expectation that belongs to the edge just taken.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, 32'({sdram_rst, sys_rst, ready, timeout_err, lock_loss_count}),
              32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int t);
    if (cyc > t) begin
      n_checks++;
      n_errors++;
      $display("FAIL goto: at cycle %0d, required <= %0d", cyc, t);
    end
    while (cyc < t) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, d2, s, s2, s3, e, l, r, p, t;

    rst = 1'b1;
    pll_lock = 1'b0;
    sdram_init_done = 1'b0;
    step();
    expect_at("reset", cyc + 1, 1, 1, 0, 0, 8'd0);
    step();

    // 1. Nominal bring-up: lock high before the first non-reset edge.
    rst = 1'b0;
    pll_lock = 1'b1;
    d = cyc;
    expect_at("s1_powerup_end", d + 14, 1, 1, 0, 0, 8'd0);
    expect_at("s1_sdram_rst_fall", d + 15, 0, 1, 0, 0, 8'd0);
    expect_at("s1_wait_done", d + 17, 0, 1, 0, 0, 8'd0);
    expect_at("s1_run", d + 18, 0, 0, 1, 0, 8'd0);
    goto_cyc(d + 17);
    sdram_init_done = 1'b1;

    // 4. Lock loss in RUN: resets assert exactly three edges later.
    goto_cyc(d + 20);
    pll_lock = 1'b0;
    sdram_init_done = 1'b0;
    e = cyc;
    expect_at("s4_run_hold", e + 2, 0, 0, 1, 0, 8'd0);
    expect_at("s4_lock_loss", e + 3, 1, 1, 0, 0, 8'd1);
    goto_cyc(e + 4);

    // 2. Glitchy lock: three low cycles during STABILIZE.
    pll_lock = 1'b1;
    d = cyc;
    expect_at("s2_stabilize", d + 5, 1, 1, 0, 0, 8'd1);
    expect_at("s2_glitch_loss", d + 6, 1, 1, 0, 0, 8'd2);
    goto_cyc(d + 3);
    pll_lock = 1'b0;
    goto_cyc(d + 6);
    pll_lock = 1'b1;
    d2 = cyc;
    expect_at("s2_relock_powerup_end", d2 + 14, 1, 1, 0, 0, 8'd2);
    expect_at("s2_relock_sdram_fall", d2 + 15, 0, 1, 0, 0, 8'd2);

    // 3. Init timeout, then a second pass with done already high on entry.
    s = d2 + 15;
    expect_at("s3_last_init_cycle", s + 15, 0, 1, 0, 0, 8'd2);
    expect_at("s3_timeout", s + 16, 1, 1, 0, 1, 8'd2);
    expect_at("s3_pass2_powerup_end", s + 28, 1, 1, 0, 1, 8'd2);
    expect_at("s3_pass2_sdram_fall", s + 29, 0, 1, 0, 1, 8'd2);
    expect_at("s3_pass2_run", s + 30, 0, 0, 1, 1, 8'd2);
    goto_cyc(s + 28);
    sdram_init_done = 1'b1;
    goto_cyc(s + 32);

    // 5a. Lock loss on the same cycle done is sampled in SDRAM_INIT.
    pll_lock = 1'b0;
    sdram_init_done = 1'b0;
    l = cyc;
    expect_at("s5a_run_loss", l + 3, 1, 1, 0, 1, 8'd3);
    goto_cyc(l + 3);
    pll_lock = 1'b1;
    s2 = cyc + 15;
    expect_at("s5a_init_entry", s2, 0, 1, 0, 1, 8'd3);
    expect_at("s5a_before", s2 + 3, 0, 1, 0, 1, 8'd3);
    expect_at("s5a_loss_beats_done", s2 + 4, 1, 1, 0, 1, 8'd4);
    expect_at("s5a_not_run", s2 + 5, 1, 1, 0, 1, 8'd4);
    goto_cyc(s2 + 1);
    pll_lock = 1'b0;
    goto_cyc(s2 + 3);
    sdram_init_done = 1'b1;
    goto_cyc(s2 + 6);
    sdram_init_done = 1'b0;

    // Synchronous reset clears the sticky flag and the counter.
    rst = 1'b1;
    r = cyc;
    expect_at("rst_clear", r + 1, 1, 1, 0, 0, 8'd0);
    goto_cyc(r + 1);
    rst = 1'b0;
    pll_lock = 1'b1;

    // 5b. Lock loss on the terminal timeout cycle: no timeout flagged.
    s3 = cyc + 15;
    expect_at("s5b_init_entry", s3, 0, 1, 0, 0, 8'd0);
    expect_at("s5b_last_cycle", s3 + 15, 0, 1, 0, 0, 8'd0);
    expect_at("s5b_loss_no_timeout", s3 + 16, 1, 1, 0, 0, 8'd1);
    expect_at("s5b_still_no_timeout", s3 + 17, 1, 1, 0, 0, 8'd1);
    goto_cyc(s3 + 13);
    pll_lock = 1'b0;
    goto_cyc(s3 + 17);

    // 6. Saturation: 300 further lock losses, each taken from STABILIZE.
    for (int i = 0; i < 300; i++) begin
      t = cyc;
      pll_lock = 1'b1;
      if (i == 0)   expect_at("s6_first_toggle", t + 6, 1, 1, 0, 0, 8'd2);
      if (i == 252) expect_at("s6_count_254", t + 6, 1, 1, 0, 0, 8'd254);
      if (i == 254) expect_at("s6_saturated", t + 6, 1, 1, 0, 0, 8'd255);
      if (i == 299) expect_at("s6_final", t + 6, 1, 1, 0, 0, 8'd255);
      goto_cyc(t + 3);
      pll_lock = 1'b0;
      goto_cyc(t + 6);
    end

    // Reset in the middle of POWERUP, then a full re-sequence.
    pll_lock = 1'b1;
    p = cyc;
    expect_at("s6_mid_powerup", p + 9, 1, 1, 0, 0, 8'd255);
    expect_at("s6_rst_mid_powerup", p + 10, 1, 1, 0, 0, 8'd0);
    expect_at("s6_after_rst_powerup_end", p + 24, 1, 1, 0, 0, 8'd0);
    expect_at("s6_after_rst_sdram_fall", p + 25, 0, 1, 0, 0, 8'd0);
    goto_cyc(p + 9);
    rst = 1'b1;
    goto_cyc(p + 10);
    rst = 1'b0;
    goto_cyc(p + 27);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
